// File: rtl/qr_inv_pkg.sv
// Shared encodings for the QR-then-inverse datapath: register file operations, controller
// states and the per-step CORDIC launch masks.
package qr_inv_pkg;

    localparam int unsigned UNIT_W = 3;

    typedef logic [1:0] opr_t;
    localparam opr_t OPR_IDLE    = 2'b00;
    localparam opr_t OPR_CORDIC  = 2'b01;
    localparam opr_t OPR_INVERSE = 2'b10;

    typedef logic [3:0] ctrl_state_t;
    localparam ctrl_state_t ST_IDLE      = 4'd0;
    localparam ctrl_state_t ST_ENTER     = 4'd1;
    localparam ctrl_state_t ST_WAIT_DONE = 4'd2;
    localparam ctrl_state_t ST_SETTLE    = 4'd3;
    localparam ctrl_state_t ST_FIRE      = 4'd4;
    localparam ctrl_state_t ST_GAP       = 4'd5;
    localparam ctrl_state_t ST_INV_OFFER = 4'd6;
    localparam ctrl_state_t ST_SWITCH    = 4'd7;
    localparam ctrl_state_t ST_GAP2      = 4'd8;
    localparam ctrl_state_t ST_FINISH    = 4'd9;

    localparam logic [2:0] LAST_STEP = 3'd5;

    // Bit order {rot2, rot1, vec}
    typedef logic [UNIT_W-1:0] unit_mask_t;
    localparam unit_mask_t U_STEP0 = 3'b001;
    localparam unit_mask_t U_STEP1 = 3'b111;
    localparam unit_mask_t U_STEP2 = 3'b110;
    localparam unit_mask_t U_STEP3 = 3'b001;
    localparam unit_mask_t U_STEP4 = 3'b010;
    localparam unit_mask_t U_STEP5 = 3'b000;

    function automatic unit_mask_t step_units(input logic [2:0] step);
        case (step)
            3'd0:    return U_STEP0;
            3'd1:    return U_STEP1;
            3'd2:    return U_STEP2;
            3'd3:    return U_STEP3;
            3'd4:    return U_STEP4;
            default: return U_STEP5;
        endcase
    endfunction

endpackage

// File: rtl/qr_inv_seq_ctrl_if.sv
// Handshake bundle between the sequencing controller and the register file, CORDIC units
// and inverse block.
interface qr_inv_seq_ctrl_if;
    logic [1:0] opr_regfile;
    logic       valid_regfile;
    logic       vec_start;
    logic       rot1_start;
    logic       rot2_start;
    logic       vec_done;
    logic       rot1_done;
    logic       rot2_done;
    logic       inv_valid;
    logic       inv_ready;
    logic [1:0] inv_idx;

    modport master (
        output opr_regfile, valid_regfile, vec_start, rot1_start, rot2_start, inv_valid,
               inv_idx,
        input  vec_done, rot1_done, rot2_done, inv_ready
    );

    modport slave (
        input  opr_regfile, valid_regfile, vec_start, rot1_start, rot2_start, inv_valid,
               inv_idx,
        output vec_done, rot1_done, rot2_done, inv_ready
    );
endinterface

// File: rtl/qr_done_tracker.sv
// Sticky mask of CORDIC units still owing a done pulse, plus the wait-phase timeout counter.
module qr_done_tracker
    import qr_inv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       load,
    input  unit_mask_t load_mask,
    input  unit_mask_t done_in,
    input  logic       run,
    output logic       all_done,
    output logic       timed_out
);
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    unit_mask_t      pend_q, pend_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    // A done arriving this cycle already counts, so the waiter can leave without a bubble
    assign all_done  = ~|(pend_q & ~done_in);
    assign timed_out = (TIMEOUT_CYCLES != 0) && run && !all_done && (cnt_q == CNT_LAST);

    always_comb begin
        pend_d = load ? load_mask : (pend_q & ~done_in);
        cnt_d  = run ? cnt_q + TO_W'(1) : '0;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/qr_inv_seq_ctrl.sv
// Sequencing master: walks the register file through six CORDIC steps, then offers the three
// R pairs to the inverse block. All outputs are registered.
module qr_inv_seq_ctrl
    import qr_inv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    qr_inv_seq_ctrl_if.master ctl
);
    ctrl_state_t state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic        gap_q, gap_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    opr_t        opr_q, opr_d;
    logic        valid_q, valid_d;
    unit_mask_t  ustart_q, ustart_d;
    logic        inv_valid_q, inv_valid_d;
    logic [1:0]  inv_idx_q, inv_idx_d;
    logic        pend_load, waiting, all_done, timed_out;
    unit_mask_t  pend_mask, done_vec;

    assign done_vec = {ctl.rot2_done, ctl.rot1_done, ctl.vec_done};
    assign waiting  = (state_q == ST_WAIT_DONE);

    qr_done_tracker #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_tracker (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .load      (pend_load),
        .load_mask (pend_mask),
        .done_in   (done_vec),
        .run       (waiting),
        .all_done  (all_done),
        .timed_out (timed_out)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        gap_d       = gap_q;
        busy_d      = busy_q;
        opr_d       = opr_q;
        inv_valid_d = inv_valid_q;
        inv_idx_d   = inv_idx_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        valid_d     = 1'b0;
        ustart_d    = '0;
        pend_load   = 1'b0;
        pend_mask   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ENTER;
                    opr_d     = OPR_CORDIC;
                    busy_d    = 1'b1;
                    step_d    = 3'd0;
                    inv_idx_d = 2'd0;
                    pend_load = 1'b1;
                end
            end
            ST_ENTER: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (all_done) begin
                    state_d = ST_SETTLE;
                end else if (timed_out) begin
                    state_d = ST_FINISH;
                    opr_d   = OPR_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            ST_SETTLE: begin
                // Pulses are registered here so they are visible while in FIRE
                state_d = ST_FIRE;
                if (step_q != LAST_STEP) begin
                    valid_d  = 1'b1;
                    ustart_d = step_units(step_q);
                end
            end
            ST_FIRE: begin
                if (step_q == LAST_STEP) begin
                    state_d = ST_INV_OFFER;
                end else begin
                    pend_load = 1'b1;
                    pend_mask = step_units(step_q);
                    step_d    = step_q + 3'd1;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d = ~gap_q;
                if (gap_q) state_d = ST_WAIT_DONE;
            end
            ST_INV_OFFER: begin
                if (!inv_valid_q) begin
                    inv_valid_d = 1'b1;
                end else if (ctl.inv_ready) begin
                    inv_valid_d = 1'b0;
                    valid_d     = 1'b1;
                    if (inv_idx_q == 2'd0) begin
                        state_d = ST_SWITCH;
                        opr_d   = OPR_INVERSE;
                    end else if (inv_idx_q == 2'd1) begin
                        state_d = ST_GAP2;
                    end else begin
                        state_d = ST_FINISH;
                        opr_d   = OPR_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SWITCH: begin
                state_d   = ST_INV_OFFER;
                inv_idx_d = 2'd1;
            end
            ST_GAP2: begin
                gap_d = ~gap_q;
                if (gap_q) begin
                    state_d   = ST_INV_OFFER;
                    inv_idx_d = inv_idx_q + 2'd1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= ST_IDLE;
            step_q      <= 3'd0;
            gap_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            opr_q       <= OPR_IDLE;
            valid_q     <= 1'b0;
            ustart_q    <= '0;
            inv_valid_q <= 1'b0;
            inv_idx_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            gap_q       <= gap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            opr_q       <= opr_d;
            valid_q     <= valid_d;
            ustart_q    <= ustart_d;
            inv_valid_q <= inv_valid_d;
            inv_idx_q   <= inv_idx_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign ctl.opr_regfile   = opr_q;
    assign ctl.valid_regfile = valid_q;
    assign ctl.vec_start     = ustart_q[0];
    assign ctl.rot1_start    = ustart_q[1];
    assign ctl.rot2_start    = ustart_q[2];
    assign ctl.inv_valid     = inv_valid_q;
    assign ctl.inv_idx       = inv_idx_q;

endmodule

// File: tb/tb_qr_inv_seq_ctrl.sv
// Scoreboard bench for qr_inv_seq_ctrl: directed runs push expected output events with
// hand-computed cycle offsets; a monitor pops and compares each observed event.
module tb_qr_inv_seq_ctrl;

    typedef struct {
        int         cyc;
        logic       v;
        logic [2:0] st;
        logic [1:0] opr;
        logic [1:0] idx;
        logic       dn;
        logic       er;
        logic       bz;
    } ev_t;

    logic CLK = 1'b0;
    logic RST_n;
    logic start;
    logic busy, done, err;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_valid = 0, n_vec = 0, n_rot1 = 0, n_rot2 = 0;
    int   lat[3];
    int   rem[3];
    int   rot2_n = 0;
    int   drop_at = 0;
    ev_t  exp_q[$];

    qr_inv_seq_ctrl_if bus ();

    qr_inv_seq_ctrl #(
        .TIMEOUT_CYCLES (20),
        .TO_W           (8)
    ) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .ctl   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic v, input logic [2:0] st, input logic [1:0] opr,
                           input logic [1:0] idx, input logic dn, input logic er, input logic bz);
        ev_t e;
        e.cyc = c; e.v = v; e.st = st; e.opr = opr; e.idx = idx; e.dn = dn; e.er = er; e.bz = bz;
        exp_q.push_back(e);
    endtask

    // Full run: five FIRE pulses, three inverse handshakes, done with the last one
    task automatic push_full(input int t0, input int o0, input int o1, input int o2, input int o3,
                             input int o4, input int o5, input int o6, input int o7);
        push_ev(t0 + o0, 1'b1, 3'b001, 2'b01, 2'd0, 1'b0, 1'b0, 1'b1);
        push_ev(t0 + o1, 1'b1, 3'b111, 2'b01, 2'd0, 1'b0, 1'b0, 1'b1);
        push_ev(t0 + o2, 1'b1, 3'b110, 2'b01, 2'd0, 1'b0, 1'b0, 1'b1);
        push_ev(t0 + o3, 1'b1, 3'b001, 2'b01, 2'd0, 1'b0, 1'b0, 1'b1);
        push_ev(t0 + o4, 1'b1, 3'b010, 2'b01, 2'd0, 1'b0, 1'b0, 1'b1);
        push_ev(t0 + o5, 1'b1, 3'b000, 2'b10, 2'd0, 1'b0, 1'b0, 1'b1);
        push_ev(t0 + o6, 1'b1, 3'b000, 2'b10, 2'd1, 1'b0, 1'b0, 1'b1);
        push_ev(t0 + o7, 1'b1, 3'b000, 2'b00, 2'd2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic push_nominal(input int t0);
        push_full(t0, 4, 10, 16, 22, 28, 37, 40, 44);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!done && n < max_cyc);
        chk(name, done, 1);
    endtask

    // CORDIC unit models: done pulses lat[u] cycles after the start cycle
    initial begin
        logic [2:0] st;
        logic [2:0] dv;
        bus.vec_done = 1'b0; bus.rot1_done = 1'b0; bus.rot2_done = 1'b0;
        rem = '{0, 0, 0};
        forever begin
            @(negedge CLK);
            st = {bus.rot2_start, bus.rot1_start, bus.vec_start};
            dv = 3'b000;
            if (!RST_n) begin
                rem = '{0, 0, 0};
            end else begin
                for (int u = 0; u < 3; u++) begin
                    if (rem[u] > 0) begin
                        rem[u]--;
                        if (rem[u] == 0) dv[u] = 1'b1;
                    end
                    if (st[u]) begin
                        if (u == 2) rot2_n++;
                        if (!(u == 2 && rot2_n == drop_at)) rem[u] = lat[u];
                    end
                end
            end
            bus.vec_done = dv[0]; bus.rot1_done = dv[1]; bus.rot2_done = dv[2];
        end
    end

    // Monitor: every output event is matched against the head of the scoreboard
    initial begin
        ev_t        e;
        logic [2:0] gst;
        forever begin
            @(negedge CLK);
            gst = {bus.rot2_start, bus.rot1_start, bus.vec_start};
            if (RST_n && (bus.valid_regfile || (gst != 3'b000) || done || err)) begin
                if (bus.valid_regfile) n_valid++;
                if (gst[0]) n_vec++;
                if (gst[1]) n_rot1++;
                if (gst[2]) n_rot2++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event @%0d: v=%0b st=%03b opr=%02b idx=%0d dn=%0b er=%0b, required none",
                             cyc, bus.valid_regfile, gst, bus.opr_regfile, bus.inv_idx, done, err);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.valid_regfile !== e.v || gst !== e.st ||
                        bus.opr_regfile !== e.opr || bus.inv_idx !== e.idx || done !== e.dn ||
                        err !== e.er || busy !== e.bz) begin
                        n_bad++;
                        $display("FAIL event: got @%0d v=%0b st=%03b opr=%02b idx=%0d dn=%0b er=%0b bz=%0b, required @%0d v=%0b st=%03b opr=%02b idx=%0d dn=%0b er=%0b bz=%0b",
                                 cyc, bus.valid_regfile, gst, bus.opr_regfile, bus.inv_idx, done,
                                 err, busy, e.cyc, e.v, e.st, e.opr, e.idx, e.dn, e.er, e.bz);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   t0;
        logic found;
        RST_n = 1'b0;
        start = 1'b0;
        bus.inv_ready = 1'b1;
        lat = '{4, 4, 4};
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {busy, done, err, bus.opr_regfile, bus.valid_regfile, bus.vec_start,
            bus.rot1_start, bus.rot2_start, bus.inv_valid, bus.inv_idx}, 0);
        RST_n = 1'b1;
        @(negedge CLK);
        chk("idle_after_release", {busy, bus.opr_regfile, bus.inv_valid}, 0);

        // Nominal run
        n_valid = 0; n_vec = 0; n_rot1 = 0; n_rot2 = 0;
        push_nominal(cyc);
        pulse_start();
        chk("busy_in_run", {busy, bus.opr_regfile}, 3'b101);
        wait_done("nominal_done", 200);
        @(negedge CLK);
        chk("cnt_valid", n_valid, 8);
        chk("cnt_vec", n_vec, 3);
        chk("cnt_rot1", n_rot1, 3);
        chk("cnt_rot2", n_rot2, 2);
        chk("idle_after_done", {busy, bus.opr_regfile}, 0);

        // Skewed latencies plus inv_ready held low on pair 1
        lat = '{6, 4, 9};
        push_full(cyc, 4, 12, 23, 34, 42, 51, 59, 63);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK);
            found = bus.valid_regfile && bus.opr_regfile == 2'b10;
        end
        chk("switch_seen", found, 1);
        bus.inv_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            found = bus.inv_valid;
        end
        chk("pair1_offered", found, 1);
        for (int i = 0; i < 5; i++) begin
            chk("pair1_hold", {bus.inv_valid, bus.inv_idx, bus.valid_regfile}, 4'b1010);
            @(negedge CLK);
        end
        bus.inv_ready = 1'b1;
        wait_done("skew_done", 100);
        @(negedge CLK);

        // Timeout: second rot2 start (step 2) never completes
        lat = '{4, 4, 4};
        rot2_n = 0;
        drop_at = 2;
        t0 = cyc;
        push_ev(t0 + 4, 1'b1, 3'b001, 2'b01, 2'd0, 1'b0, 1'b0, 1'b1);
        push_ev(t0 + 10, 1'b1, 3'b111, 2'b01, 2'd0, 1'b0, 1'b0, 1'b1);
        push_ev(t0 + 16, 1'b1, 3'b110, 2'b01, 2'd0, 1'b0, 1'b0, 1'b1);
        push_ev(t0 + 39, 1'b0, 3'b000, 2'b00, 2'd0, 1'b1, 1'b1, 1'b0);
        pulse_start();
        wait_done("timeout_done", 100);
        chk("timeout_err", err, 1);
        @(negedge CLK);
        chk("timeout_idle", {busy, done, err, bus.opr_regfile}, 0);
        drop_at = 0;

        // start while busy and in the done cycle are ignored; one cycle later starts a run
        t0 = cyc;
        push_nominal(t0);
        pulse_start();
        repeat (7) @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done("busy_start_done", 200);
        start = 1'b1;
        push_nominal(cyc + 1);
        @(negedge CLK);
        @(negedge CLK);
        start = 1'b0;
        wait_done("restart_done", 200);
        @(negedge CLK);

        // Reset during the GAP after the step 3 launch
        t0 = cyc;
        push_nominal(t0);
        pulse_start();
        repeat (22) @(negedge CLK);
        RST_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", {busy, done, err, bus.opr_regfile, bus.valid_regfile,
            bus.vec_start, bus.rot1_start, bus.rot2_start, bus.inv_valid, bus.inv_idx}, 0);
        chk("events_left_at_reset", exp_q.size(), 4);
        exp_q.delete();
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        push_nominal(cyc);
        pulse_start();
        wait_done("post_reset_done", 200);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
